// File: rtl/mod_recon_if.sv
// mod_recon_if: operand/result bundle for the mod_recon dividend rebuilder.
//   Start, q, b, rem : request and operands (driven by the master)
//   Busy, Done       : handshake status (driven by the slave)
//   a, Ovf, RemErr   : reconstructed dividend and flags (driven by the slave)
interface mod_recon_if #(
    parameter int unsigned DATAWIDTH = 8
);
    logic                 Start;
    logic [DATAWIDTH-1:0] q;
    logic [DATAWIDTH-1:0] b;
    logic [DATAWIDTH-1:0] rem;
    logic                 Busy;
    logic                 Done;
    logic [DATAWIDTH-1:0] a;
    logic                 Ovf;
    logic                 RemErr;

    modport master (
        output Start, q, b, rem,
        input  Busy, Done, a, Ovf, RemErr
    );

    modport slave (
        input  Start, q, b, rem,
        output Busy, Done, a, Ovf, RemErr
    );
endinterface

// File: rtl/mod_recon.sv
// mod_recon: rebuilds a = q*b + rem with an LSB-first shift-add multiplier.
//   Clk  : rising-edge clock
//   Rst  : synchronous active-high reset
//   bus  : mod_recon_if slave (Start/q/b/rem in, Busy/Done/a/Ovf/RemErr out)
// One operation takes DATAWIDTH multiply cycles plus one add cycle; Done pulses
// on the following cycle together with the new a/Ovf/RemErr.
module mod_recon #(
    parameter int unsigned DATAWIDTH = 8
) (
    input  logic          Clk,
    input  logic          Rst,
    mod_recon_if.slave    bus
);
    localparam int unsigned DW = DATAWIDTH;
    localparam int unsigned AW = 2 * DATAWIDTH + 1;
    localparam int unsigned CW = $clog2(DATAWIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          r_state,  w_state_nxt;
    logic            r_busy,   w_busy_nxt;
    logic            r_done,   w_done_nxt;
    logic [DW-1:0]   r_a,      w_a_nxt;
    logic            r_ovf,    w_ovf_nxt;
    logic            r_remerr, w_remerr_nxt;
    logic            r_pend,   w_pend_nxt;
    logic [DW-1:0]   r_q,      w_q_nxt;
    logic [AW-1:0]   r_mcand,  w_mcand_nxt;
    logic [DW-1:0]   r_rem,    w_rem_nxt;
    logic [AW-1:0]   r_acc,    w_acc_nxt;
    logic [CW-1:0]   r_cnt,    w_cnt_nxt;

    logic [AW-1:0]   w_acc_mul;
    logic [AW-1:0]   w_acc_add;

    assign w_acc_mul = r_acc + r_mcand;
    assign w_acc_add = r_acc + AW'(r_rem);

    // State and datapath registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_a      <= '0;
            r_ovf    <= 1'b0;
            r_remerr <= 1'b0;
            r_pend   <= 1'b0;
            r_q      <= '0;
            r_mcand  <= '0;
            r_rem    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_a      <= w_a_nxt;
            r_ovf    <= w_ovf_nxt;
            r_remerr <= w_remerr_nxt;
            r_pend   <= w_pend_nxt;
            r_q      <= w_q_nxt;
            r_mcand  <= w_mcand_nxt;
            r_rem    <= w_rem_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Next-state and next-register values
    always_comb begin
        w_state_nxt  = r_state;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_a_nxt      = r_a;
        w_ovf_nxt    = r_ovf;
        w_remerr_nxt = r_remerr;
        w_pend_nxt   = r_pend;
        w_q_nxt      = r_q;
        w_mcand_nxt  = r_mcand;
        w_rem_nxt    = r_rem;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;

        unique case (r_state)
            IDLE, DONE: begin
                if (bus.Start) begin
                    w_q_nxt     = bus.q;
                    w_mcand_nxt = AW'(bus.b);
                    w_rem_nxt   = bus.rem;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = CW'(DW);
                    // Held until DONE so the visible RemErr keeps the last result meanwhile
                    w_pend_nxt  = (bus.b == '0) || (bus.rem >= bus.b);
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = MUL;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            MUL: begin
                // q shifts right and b shifts left, so q[0]/mcand track the current bit index
                if (r_q[0]) begin
                    w_acc_nxt = w_acc_mul;
                end
                w_q_nxt     = r_q >> 1;
                w_mcand_nxt = r_mcand << 1;
                w_cnt_nxt   = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = ADD;
                end
            end
            ADD: begin
                // Results are registered on this edge so they appear with Done
                w_acc_nxt    = w_acc_add;
                w_a_nxt      = w_acc_add[DW-1:0];
                w_ovf_nxt    = |w_acc_add[AW-1:DW];
                w_remerr_nxt = r_pend;
                w_done_nxt   = 1'b1;
                w_busy_nxt   = 1'b0;
                w_state_nxt  = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.Busy   = r_busy;
    assign bus.Done   = r_done;
    assign bus.a      = r_a;
    assign bus.Ovf    = r_ovf;
    assign bus.RemErr = r_remerr;
endmodule

// File: tb/tb_mod_recon.sv
// tb_mod_recon: randomized self-checking bench for mod_recon (DATAWIDTH=8).
// Expected results come from plain integer arithmetic on q*b+rem.
module tb_mod_recon;
    localparam int MAXC = 24;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mod_recon_if #(.DATAWIDTH(8)) bus ();

    mod_recon #(.DATAWIDTH(8)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: a = low 8 bits of q*b+rem, Ovf if it exceeds 255, RemErr if b==0 or rem>=b
    function automatic void model(input int q, input int b, input int r,
                                  output logic [7:0] ea, output logic eovf, output logic erem);
        int s;
        s    = q * b + r;
        ea   = 8'(s % 256);
        eovf = (s > 255);
        erem = (b == 0) || (r >= b);
    endfunction

    // Starts an operation at edge 0 and records per-cycle Busy/Done for cycles 1..MAXC.
    // start_mask[k] drives Start during cycle k (with operands q2/b2/r2); Rst is driven
    // during cycle rst_cyc when nonzero, and outputs are snapshotted the cycle after.
    task automatic run_op(input logic [7:0] iq, input logic [7:0] ib, input logic [7:0] ir,
                          input logic [31:0] start_mask,
                          input logic [7:0] q2, input logic [7:0] b2, input logic [7:0] r2,
                          input int rst_cyc,
                          output logic [31:0] busy_bits, output logic [31:0] done_bits,
                          output logic [7:0] a1, output logic o1, output logic e1,
                          output logic [7:0] a2, output logic o2, output logic e2,
                          output logic [7:0] a_c1,
                          output logic [7:0] a_rs, output logic o_rs, output logic e_rs);
        int ndone;
        busy_bits = '0;
        done_bits = '0;
        a1 = '0; o1 = 1'b0; e1 = 1'b0;
        a2 = '0; o2 = 1'b0; e2 = 1'b0;
        a_c1 = '0; a_rs = '0; o_rs = 1'b0; e_rs = 1'b0;
        ndone = 0;
        @(negedge clk);
        bus.Start = 1'b1;
        bus.q     = iq;
        bus.b     = ib;
        bus.rem   = ir;
        @(posedge clk);
        for (int k = 1; k <= MAXC; k++) begin
            @(negedge clk);
            busy_bits[k] = bus.Busy;
            done_bits[k] = bus.Done;
            if (k == 1) a_c1 = bus.a;
            if (bus.Done) begin
                if (ndone == 0) begin a1 = bus.a; o1 = bus.Ovf; e1 = bus.RemErr; end
                else            begin a2 = bus.a; o2 = bus.Ovf; e2 = bus.RemErr; end
                ndone++;
            end
            if (rst_cyc != 0 && k == rst_cyc + 1) begin
                a_rs = bus.a; o_rs = bus.Ovf; e_rs = bus.RemErr;
            end
            bus.Start = start_mask[k];
            if (start_mask[k]) begin
                bus.q = q2; bus.b = b2; bus.rem = r2;
            end else begin
                bus.q = 8'($urandom); bus.b = 8'($urandom); bus.rem = 8'($urandom);
            end
            rst = (rst_cyc != 0 && k == rst_cyc);
        end
        bus.Start = 1'b0;
        rst       = 1'b0;
    endtask

    logic [31:0] bb, db;
    logic [7:0]  ga1, ga2, gc1, grs;
    logic        go1, ge1, go2, ge2, gors, gers;
    logic [7:0]  ea, ea2;
    logic        eo, ee, eo2, ee2;
    logic [7:0]  prev_a;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; bus.Start = 1'b1;
        bus.q = 8'd13; bus.b = 8'd7; bus.rem = 8'd5;
        repeat (2) @(negedge clk);
        checks++; if (bus.Busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b expected 0", bus.Busy); end
        checks++; if (bus.Done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b expected 0", bus.Done); end
        checks++; if (bus.a !== 8'd0)      begin errors++; $display("FAIL reset_a got %0d expected 0", bus.a); end
        checks++; if (bus.Ovf !== 1'b0)    begin errors++; $display("FAIL reset_ovf got %b expected 0", bus.Ovf); end
        checks++; if (bus.RemErr !== 1'b0) begin errors++; $display("FAIL reset_remerr got %b expected 0", bus.RemErr); end
        rst = 1'b0; bus.Start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.Busy !== 1'b0)   begin errors++; $display("FAIL reset_start_wins got busy %b expected 0", bus.Busy); end
        prev_a = 8'd0;
    endtask

    task automatic test_vectors();
        logic [7:0] tq [5] = '{8'd13, 8'd255, 8'd0, 8'd4, 8'd1};
        logic [7:0] tb [5] = '{8'd7,  8'd2,   8'd0, 8'd7, 8'd200};
        logic [7:0] tr [5] = '{8'd5,  8'd1,   8'd3, 8'd7, 8'd199};
        for (int i = 0; i < 5; i++) begin
            run_op(tq[i], tb[i], tr[i], 32'h0, 8'd0, 8'd0, 8'd0, 0,
                   bb, db, ga1, go1, ge1, ga2, go2, ge2, gc1, grs, gors, gers);
            model(int'(tq[i]), int'(tb[i]), int'(tr[i]), ea, eo, ee);
            checks++; if (db !== 32'h400)  begin errors++; $display("FAIL vec%0d_done_cycles got %h expected %h", i, db, 32'h400); end
            checks++; if (bb !== 32'h3FE)  begin errors++; $display("FAIL vec%0d_busy_cycles got %h expected %h", i, bb, 32'h3FE); end
            checks++; if (ga1 !== ea)      begin errors++; $display("FAIL vec%0d_a got %0d expected %0d", i, ga1, ea); end
            checks++; if (go1 !== eo)      begin errors++; $display("FAIL vec%0d_ovf got %b expected %b", i, go1, eo); end
            checks++; if (ge1 !== ee)      begin errors++; $display("FAIL vec%0d_remerr got %b expected %b", i, ge1, ee); end
            checks++; if (gc1 !== prev_a)  begin errors++; $display("FAIL vec%0d_a_hold got %0d expected %0d", i, gc1, prev_a); end
            prev_a = ea;
        end
    endtask

    task automatic test_ignored_start();
        run_op(8'd13, 8'd7, 8'd5, 32'h208, 8'd100, 8'd3, 8'd1, 0,
               bb, db, ga1, go1, ge1, ga2, go2, ge2, gc1, grs, gors, gers);
        checks++; if (db !== 32'h400) begin errors++; $display("FAIL ignored_done_cycles got %h expected %h", db, 32'h400); end
        checks++; if (ga1 !== 8'd96)  begin errors++; $display("FAIL ignored_a got %0d expected 96", ga1); end
        checks++; if (bb !== 32'h3FE) begin errors++; $display("FAIL ignored_busy got %h expected %h", bb, 32'h3FE); end
        prev_a = 8'd96;
    endtask

    task automatic test_back_to_back();
        run_op(8'd20, 8'd9, 8'd4, 32'h7FE, 8'd37, 8'd6, 8'd5, 0,
               bb, db, ga1, go1, ge1, ga2, go2, ge2, gc1, grs, gors, gers);
        model(20, 9, 4, ea, eo, ee);
        model(37, 6, 5, ea2, eo2, ee2);
        checks++; if (db !== 32'h100400) begin errors++; $display("FAIL b2b_done_cycles got %h expected %h", db, 32'h100400); end
        checks++; if (bb !== 32'hFFBFE)  begin errors++; $display("FAIL b2b_busy_cycles got %h expected %h", bb, 32'hFFBFE); end
        checks++; if (ga1 !== ea)        begin errors++; $display("FAIL b2b_a1 got %0d expected %0d", ga1, ea); end
        checks++; if (ga2 !== ea2)       begin errors++; $display("FAIL b2b_a2 got %0d expected %0d", ga2, ea2); end
        checks++; if (go2 !== eo2 || ge2 !== ee2) begin errors++; $display("FAIL b2b_flags2 got %b%b expected %b%b", go2, ge2, eo2, ee2); end
        prev_a = ea2;
    endtask

    task automatic test_reset_mid();
        // Leave nonzero outputs behind so the reset clearing is observable
        run_op(8'd255, 8'd2, 8'd1, 32'h0, 8'd0, 8'd0, 8'd0, 0,
               bb, db, ga1, go1, ge1, ga2, go2, ge2, gc1, grs, gors, gers);
        run_op(8'd3, 8'd0, 8'd9, 32'h0, 8'd0, 8'd0, 8'd0, 5,
               bb, db, ga1, go1, ge1, ga2, go2, ge2, gc1, grs, gors, gers);
        checks++; if (db !== 32'h0)  begin errors++; $display("FAIL rstmid_done got %h expected 0", db); end
        checks++; if (bb !== 32'h3E) begin errors++; $display("FAIL rstmid_busy got %h expected %h", bb, 32'h3E); end
        checks++; if (grs !== 8'd0 || gors !== 1'b0 || gers !== 1'b0)
            begin errors++; $display("FAIL rstmid_outputs got a=%0d ovf=%b remerr=%b expected 0 0 0", grs, gors, gers); end
        run_op(8'd6, 8'd11, 8'd10, 32'h0, 8'd0, 8'd0, 8'd0, 0,
               bb, db, ga1, go1, ge1, ga2, go2, ge2, gc1, grs, gors, gers);
        checks++; if (db !== 32'h400) begin errors++; $display("FAIL rstmid_fresh_done got %h expected %h", db, 32'h400); end
        checks++; if (ga1 !== 8'd76)  begin errors++; $display("FAIL rstmid_fresh_a got %0d expected 76", ga1); end
        prev_a = 8'd76;
    endtask

    task automatic test_random();
        logic [7:0] rq, rb, rr;
        for (int i = 0; i < 200; i++) begin
            rq = 8'($urandom); rb = 8'($urandom); rr = 8'($urandom);
            run_op(rq, rb, rr, 32'h0, 8'd0, 8'd0, 8'd0, 0,
                   bb, db, ga1, go1, ge1, ga2, go2, ge2, gc1, grs, gors, gers);
            model(int'(rq), int'(rb), int'(rr), ea, eo, ee);
            checks++;
            if (db !== 32'h400 || ga1 !== ea || go1 !== eo || ge1 !== ee) begin
                errors++;
                $display("FAIL random q=%0d b=%0d rem=%0d got done=%h a=%0d ovf=%b remerr=%b expected done=%h a=%0d ovf=%b remerr=%b",
                         rq, rb, rr, db, ga1, go1, ge1, 32'h400, ea, eo, ee);
            end
        end
    endtask

    task automatic test_round_trip();
        int x, d;
        for (int i = 0; i < 1000; i++) begin
            x = int'($urandom_range(255, 0));
            d = int'($urandom_range(255, 1));
            run_op(8'(x / d), 8'(d), 8'(x % d), 32'h0, 8'd0, 8'd0, 8'd0, 0,
                   bb, db, ga1, go1, ge1, ga2, go2, ge2, gc1, grs, gors, gers);
            checks++;
            if (db !== 32'h400 || ga1 !== 8'(x) || go1 !== 1'b0 || ge1 !== 1'b0) begin
                errors++;
                $display("FAIL round_trip x=%0d b=%0d got done=%h a=%0d ovf=%b remerr=%b expected a=%0d ovf=0 remerr=0",
                         x, d, db, ga1, go1, ge1, x);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.Start = 1'b0;
        bus.q     = '0;
        bus.b     = '0;
        bus.rem   = '0;
        test_reset();
        test_vectors();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_round_trip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mod_recon.md
# mod_recon

Sequential inverse of the modulo/divide datapath: it rebuilds a dividend from a quotient, divisor and remainder as a = q*b + rem, using an iterative shift-add multiplier. It sits beside the modulo and divide components in the generated datapath. Scheduled code uses it to rebuild or cross-check operands without instantiating a full combinational multiplier. A Start/Busy/Done handshake sequences each operation, and the block flags results that overflow DATAWIDTH or remainders that are inconsistent with the divisor.

## Interface
- DATAWIDTH, 8, width of q, b, rem and a (unsigned)
- Clk  input  1  single clock; all state updates on rising edge
- Rst  input  1  synchronous, active-high reset
- Start  input  1  request a new operation; sampled only when Busy=0
- q  input  DATAWIDTH  quotient operand
- b  input  DATAWIDTH  divisor operand
- rem  input  DATAWIDTH  remainder operand
- Busy  output  1  operation in progress; Start ignored while high
- Done  output  1  one-cycle pulse; a/Ovf/RemErr valid from this cycle on
- a  output  DATAWIDTH  reconstructed dividend, low DATAWIDTH bits of q*b+rem
- Ovf  output  1  q*b+rem does not fit in DATAWIDTH bits
- RemErr  output  1  operands are not a legal modulo result: b==0 or rem>=b

## Operation
- States: IDLE, MUL, ADD, DONE. Reset state is IDLE.
- Reset values: Busy=0, Done=0, a=0, Ovf=0, RemErr=0, internal accumulator and bit counter 0.
- IDLE or DONE with Start=1:
  - Latch q, b and rem.
  - Clear the 2*DATAWIDTH+1-bit accumulator and load the bit counter with DATAWIDTH.
  - Compute RemErr from the latched operands and register it.
  - Enter MUL and set Busy=1.
- MUL runs one step per cycle, LSB first, for exactly DATAWIDTH cycles regardless of operand values (no early exit):
  - If the current q bit is 1, add b shifted left by the bit index into the accumulator.
  - Decrement the counter. When the counter reaches 0, go to ADD.
- ADD: add the zero-extended rem to the accumulator, then go to DONE.
- DONE:
  - Done=1 and Busy=0.
  - a = accumulator[DATAWIDTH-1:0].
  - Ovf = |accumulator[2*DATAWIDTH:DATAWIDTH].
- DONE without Start returns to IDLE on the next cycle. DONE with Start begins a new operation, so back-to-back operations are allowed.
- a, Ovf and RemErr are registered. They hold their values until the next DONE. Starting a new operation does not clear them.
- RemErr is informational only. The arithmetic still completes, and a = q*b+rem truncated. With b==0, a = rem.
- Start while Busy=1 is ignored; it is neither queued nor restarted.
- Rst during any state:
  - Abort the operation and return to IDLE the next cycle.
  - All outputs return to their reset values, and no Done pulse is produced.
- Rst and Start high in the same cycle: reset wins.

## Timing
- Start sampled high at edge 0: Busy is high during cycles 1 through DATAWIDTH+1.
- MUL occupies cycles 1 through DATAWIDTH. ADD occupies cycle DATAWIDTH+1.
- Done is high for exactly cycle DATAWIDTH+2 (cycle 10 when DATAWIDTH=8). New a, Ovf and RemErr appear in that same cycle.
- Latency is DATAWIDTH+2 cycles from the Start edge to Done.
- Throughput is one operation every DATAWIDTH+2 cycles when Start is held high or re-asserted during DONE.
- Operand inputs may change freely after the Start edge, because only the latched copies are used.

## Test plan
- DATAWIDTH=8, q=13, b=7, rem=5, Start for 1 cycle -> Done pulse at cycle 10 with a=96, Ovf=0, RemErr=0; Busy high in cycles 1 through 9.
- q=255, b=2, rem=1 -> q*b+rem=511, so a=255 and Ovf=1 at Done. Then q=0, b=0, rem=3 -> a=3, Ovf=0, RemErr=1.
- q=4, b=7, rem=7 -> a=35, RemErr=1 (rem>=b), Ovf=0. Then q=1, b=200, rem=199 -> a=143, Ovf=1, RemErr=0.
- Start high at edge 0, then pulse Start again at cycles 3 and 9 with other operands -> ignored; only the first result appears at cycle 10. Start held high through cycle 10 -> second operation's Done at cycle 20.
- Rst asserted at cycle 5 of an operation -> outputs 0 and state IDLE from cycle 6; no Done ever pulses for that operation. A fresh Start afterwards completes normally.
- Round trip over 1000 random (x, b), b≠0: feed q=x/b and rem=x%b -> every result has a=x, Ovf=0, RemErr=0.
